alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Multi-cycle, parametrised successor to the combinational datapath ALU. It adds unsigned multiply (low and high half), unsigned divide and unsigned remainder, all computed by an iterative shift-add / restoring-divide engine. Operands arrive and results leave through valid/ready handshakes, so the execute stage can stall on long operations. Single-cycle ops are delegated to the existing combinational alu and returned with one registered cycle of latency.

Parameters:
- WIDTH, 8: operand/result width in bits; must be >= 2.
- SHW, $clog2(WIDTH): shift-amount bits used from in2; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- in1  in  WIDTH  operand A (dividend / multiplicand).
- in2  in  WIDTH  operand B (divisor / multiplier / shift amount).
- alu_op  in  alu_opcode_t  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result this cycle.
- out  out  WIDTH  result.
- flags  out  alu_flags_t  carry, overflow, zero, negative.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, out='0, flags='0, all iteration registers cleared. in_ready=1 once reset deasserts.
- Accept: transfer occurs on a rising edge when in_valid && in_ready. Operands and opcode are captured at that edge, and input changes afterwards are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back single-cycle ops at full throughput.
- States:
  - IDLE: on accept of a simple op -> DONE; on accept of MUL/MULH/DIV/REM -> BUSY with count=0.
  - BUSY: performs one iteration per cycle. When count==WIDTH-1 -> DONE. in_ready=0 throughout.
  - DONE: out_valid=1. If out_ready && accept -> DONE or BUSY per the new op. If out_ready with no accept -> IDLE. If !out_ready -> hold.
- Latency:
  - Simple ops (ADD SUB AND OR XOR SLL SRL SRA): out_valid rises 1 cycle after accept.
  - Iterative ops: out_valid rises exactly WIDTH+1 cycles after accept.
- Back-pressure: while out_valid && !out_ready, out and flags hold stable. No new operation is accepted.
- Simple ops: result and flags are identical to the combinational alu for the same inputs, except that shift amount = in2[SHW-1:0] (upper bits ignored).
- MUL: low WIDTH bits of the unsigned 2*WIDTH product. carry = overflow = (high half != 0).
- MULH: high WIDTH bits of the unsigned product. carry = overflow = 0.
- DIV: unsigned quotient. REM: unsigned remainder. For both, carry=0 and overflow=0 when the divisor is nonzero.
- Divide by zero: detected at accept. DIV returns all-ones; REM returns in1; overflow=1.
  - Latency is still WIDTH+1 cycles (the engine runs, and the result is overridden at DONE entry).
- zero = (out=='0) and negative = out[WIDTH-1] for every op.
- Engine state:
  - Product/remainder accumulator: 2*WIDTH bits.
  - Iteration counter: SHW+1 bits, wraps to 0 on the DONE transition.
- Reset asserted mid-operation (BUSY or DONE) aborts immediately. The pending result is discarded and is never presented after reset releases.
- Undefined opcode values: treated as ADD.

Decomposition:
- defs_pkg additions:
  - Extend alu_opcode_t with ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM (widen the enum as needed).
  - New alu_seq_state_t {IDLE, BUSY, DONE}.
  - Helper function is_iter_op(alu_opcode_t).
- alu_flags_t is unchanged.
- Sub-module: instantiate the existing alu (WIDTH passed through) for simple ops. Its output and flags are registered on DONE entry. The iterative engine stays inline.

Test Plan (WIDTH=8):
1. ADD 0xFF+0x01 with out_ready=1 -> out_valid 1 cycle after accept, out=0x00, carry=1, zero=1, overflow=0. Back-to-back SUB 0x05-0x07 on the next cycle -> 0xFE, carry=0, negative=1.
2. MUL 0x12*0x10 -> out_valid exactly 9 cycles after accept, out=0x20, carry=overflow=1. MULH with the same operands -> 0x01, carry=0.
3. DIV 200/7 -> 0x1C, flags all 0. REM 200/7 -> 0x04. in_ready=0 for the whole BUSY phase.
4. DIV 0x55/0x00 -> 0xFF, overflow=1, negative=1, latency 9. REM 0x55/0x00 -> 0x55, overflow=1.
5. MUL result held with out_ready=0 for 5 cycles -> out/flags stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> handshake completes and the queued op is accepted in the same cycle.
6. Assert rst_n=0 at cycle 4 of a DIV -> out_valid=0 and out=0x00 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/defs_pkg.sv
// ---------------------------------------------------------------------------
// defs_pkg
//   Shared ALU definitions: opcode encoding (single-cycle ops plus the
//   iterative multiply/divide family), flag bundle, the sequencer state type
//   and a helper that classifies opcodes as iterative.
// ---------------------------------------------------------------------------
package defs_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_MULH = 4'd9,
    ALU_DIV  = 4'd10,
    ALU_REM  = 4'd11
  } alu_opcode_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_seq_state_t;

  function automatic logic is_iter_op(alu_opcode_t op);
    return (op == ALU_MUL) || (op == ALU_MULH) ||
           (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Combinational single-cycle ALU.
//   Ports:
//     in1, in2  [WIDTH]      operands (in2[SHW-1:0] is the shift amount)
//     alu_op    alu_opcode_t operation select; non-simple codes act as ADD
//     out       [WIDTH]      result
//     flags     alu_flags_t  carry, overflow, zero, negative
//   SUB carry is the "no borrow" carry (set when in1 >= in2 unsigned).
// ---------------------------------------------------------------------------
module alu
  import defs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  alu_opcode_t      alu_op,
  output logic [WIDTH-1:0] out,
  output alu_flags_t       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [SHW-1:0]   w_sh;

  always_comb begin
    w_sh  = in2[SHW-1:0];
    w_sum = '0;
    out   = '0;
    flags = '0;
    case (alu_op)
      ALU_SUB: begin
        w_sum          = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
        out            = w_sum[WIDTH-1:0];
        flags.carry    = w_sum[WIDTH];
        flags.overflow = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                         (out[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_AND: out = in1 & in2;
      ALU_OR:  out = in1 | in2;
      ALU_XOR: out = in1 ^ in2;
      ALU_SLL: out = in1 << w_sh;
      ALU_SRL: out = in1 >> w_sh;
      ALU_SRA: out = $unsigned($signed(in1) >>> w_sh);
      default: begin
        w_sum          = {1'b0, in1} + {1'b0, in2};
        out            = w_sum[WIDTH-1:0];
        flags.carry    = w_sum[WIDTH];
        flags.overflow = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                         (out[WIDTH-1] != in1[WIDTH-1]);
      end
    endcase
    flags.zero     = (out == '0);
    flags.negative = out[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Multi-cycle ALU with valid/ready handshakes on both sides. Simple ops go
//   through the combinational alu and are registered at accept (result valid
//   the following cycle). MUL/MULH/DIV/REM run WIDTH iterations of a
//   shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     in_valid/in_ready   operand handshake (in1, in2, alu_op)
//     out_valid/out_ready result handshake (out, flags)
// ---------------------------------------------------------------------------
module alu_seq
  import defs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  alu_opcode_t      alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output alu_flags_t       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  alu_seq_state_t     r_state;
  alu_seq_state_t     w_state_nxt;
  alu_opcode_t        r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_dz;
  logic [WIDTH-1:0]   r_out;
  alu_flags_t         r_flags;

  logic               w_accept;
  logic               w_last;
  logic               w_is_div;
  logic               w_new_iter;
  logic [WIDTH-1:0]   w_alu_out;
  alu_flags_t         w_alu_flags;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_rem;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_acc_init;
  logic [WIDTH-1:0]   w_res;
  alu_flags_t         w_res_flags;

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .in1    (in1),
    .in2    (in2),
    .alu_op (alu_op),
    .out    (w_alu_out),
    .flags  (w_alu_flags)
  );

  assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_new_iter = is_iter_op(alu_op);
  assign w_last     = (r_state == BUSY) && (r_cnt == CW'(WIDTH - 1));
  assign out_valid  = (r_state == DONE);
  assign out        = r_out;
  assign flags      = r_flags;

  // Multiplier: accumulator low half starts as in2; each step adds in1 to the
  // high half when the current LSB is set, then shifts right (carry included).
  // Divider: accumulator starts as {0, in1}; each step shifts the next
  // dividend bit into the partial remainder and subtracts when it fits.
  // After WIDTH steps hi/lo hold product hi/lo or remainder/quotient.
  always_comb begin
    w_is_div   = (r_op == ALU_DIV) || (r_op == ALU_REM);
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_div_rem  = r_acc[2*WIDTH-1:WIDTH-1];
    w_qbit     = (w_div_rem >= {1'b0, r_b});
    w_div_diff = w_div_rem[WIDTH-1:0] - r_b;
    if (w_is_div) begin
      w_acc_step = {(w_qbit ? w_div_diff : w_div_rem[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_qbit};
    end else begin
      w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    if ((alu_op == ALU_MUL) || (alu_op == ALU_MULH)) begin
      w_acc_init = {{WIDTH{1'b0}}, in2};
    end else begin
      w_acc_init = {{WIDTH{1'b0}}, in1};
    end
  end

  // Final result selection from the last iteration; a zero divisor seen at
  // accept overrides the engine output here.
  always_comb begin
    w_res       = '0;
    w_res_flags = '0;
    case (r_op)
      ALU_MUL: begin
        w_res                = w_acc_step[WIDTH-1:0];
        w_res_flags.carry    = |w_acc_step[2*WIDTH-1:WIDTH];
        w_res_flags.overflow = |w_acc_step[2*WIDTH-1:WIDTH];
      end
      ALU_MULH: w_res = w_acc_step[2*WIDTH-1:WIDTH];
      ALU_DIV: begin
        w_res                = r_dz ? '1 : w_acc_step[WIDTH-1:0];
        w_res_flags.overflow = r_dz;
      end
      ALU_REM: begin
        w_res                = r_dz ? r_a : w_acc_step[2*WIDTH-1:WIDTH];
        w_res_flags.overflow = r_dz;
      end
      default: w_res = '0;
    endcase
    w_res_flags.zero     = (w_res == '0);
    w_res_flags.negative = w_res[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_new_iter ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) begin
            w_state_nxt = w_new_iter ? BUSY : DONE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= ALU_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_op  <= alu_op;
      r_a   <= in1;
      r_b   <= in2;
      r_acc <= w_acc_init;
      r_cnt <= '0;
      r_dz  <= (in2 == '0);
      if (!w_new_iter) begin
        r_out   <= w_alu_out;
        r_flags <= w_alu_flags;
      end
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_step;
      if (w_last) begin
        r_cnt   <= '0;
        r_out   <= w_res;
        r_flags <= w_res_flags;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import defs_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  alu_opcode_t alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [W-1:0] out;
  alu_flags_t  flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    alu_opcode_t op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    logic [3:0]  fl;   // {carry, overflow, zero, negative}
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fl_bits();
    return {flags.carry, flags.overflow, flags.zero, flags.negative};
  endfunction

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic void model(input int op, input int a, input int b,
                                output logic [7:0] r, output logic [3:0] f,
                                output int lat);
    int  s, sa, sb, sh, rr;
    logic c, v;
    c  = 1'b0;
    v  = 1'b0;
    sh = b % W;
    sa = (a >= HALF) ? a - (1 << W) : a;
    sb = (b >= HALF) ? b - (1 << W) : b;
    case (op)
      1: begin
        rr = (a - b) & MASK;
        c  = (a >= b);
        v  = ((sa - sb) >= HALF) || ((sa - sb) < -HALF);
      end
      2: rr = a & b;
      3: rr = a | b;
      4: rr = a ^ b;
      5: rr = (a << sh) & MASK;
      6: rr = a >> sh;
      7: rr = (sa >>> sh) & MASK;
      8: begin
        s  = a * b;
        rr = s % (1 << W);
        c  = (s >= (1 << W));
        v  = c;
      end
      9: rr = (a * b) / (1 << W);
      10: begin
        rr = (b == 0) ? MASK : a / b;
        v  = (b == 0);
      end
      11: begin
        rr = (b == 0) ? a : a % b;
        v  = (b == 0);
      end
      default: begin
        s  = a + b;
        rr = s & MASK;
        c  = (s > MASK);
        v  = ((sa + sb) >= HALF) || ((sa + sb) < -HALF);
      end
    endcase
    r   = 8'(rr);
    f   = {c, v, (rr == 0), r[7]};
    lat = (op >= 8 && op <= 11) ? W + 1 : 1;
  endfunction

  // Issue one op with out_ready held high; returns result and latency counted
  // as 1 for a result visible right after the accept edge.
  task automatic issue(input alu_opcode_t op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [3:0] f, output int lat);
    int guard;
    @(negedge clk);
    alu_op    = op;
    in1       = a;
    in2       = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("accept_bound", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1      = 8'($urandom);
    in2      = 8'($urandom);
    alu_op   = alu_opcode_t'(4'($urandom));
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    r = out;
    f = fl_bits();
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] r, er;
  logic [3:0] f, ef;
  int         lat, elat;
  int         opi;
  logic [7:0] ra, rb;

  initial begin
    vecs[0]  = '{ALU_ADD,  8'hFF, 8'h01, 8'h00, 4'b1010, 1};
    vecs[1]  = '{ALU_SUB,  8'h05, 8'h07, 8'hFE, 4'b0001, 1};
    vecs[2]  = '{ALU_MUL,  8'h12, 8'h10, 8'h20, 4'b1100, 9};
    vecs[3]  = '{ALU_MULH, 8'h12, 8'h10, 8'h01, 4'b0000, 9};
    vecs[4]  = '{ALU_DIV,  8'hC8, 8'h07, 8'h1C, 4'b0000, 9};
    vecs[5]  = '{ALU_REM,  8'hC8, 8'h07, 8'h04, 4'b0000, 9};
    vecs[6]  = '{ALU_DIV,  8'h55, 8'h00, 8'hFF, 4'b0101, 9};
    vecs[7]  = '{ALU_REM,  8'h55, 8'h00, 8'h55, 4'b0100, 9};
    vecs[8]  = '{ALU_SRA,  8'h80, 8'h0B, 8'hF0, 4'b0001, 1};
    vecs[9]  = '{ALU_SLL,  8'h81, 8'h09, 8'h02, 4'b0000, 1};
    vecs[10] = '{ALU_SRL,  8'h81, 8'h01, 8'h40, 4'b0000, 1};
    vecs[11] = '{ALU_ADD,  8'h7F, 8'h01, 8'h80, 4'b0101, 1};
    vecs[12] = '{alu_opcode_t'(4'd14), 8'h03, 8'h04, 8'h07, 4'b0000, 1};
    vecs[13] = '{ALU_XOR,  8'hAA, 8'hAA, 8'h00, 4'b0010, 1};
    vecs[14] = '{ALU_MUL,  8'hFF, 8'hFF, 8'h01, 4'b1100, 9};
    vecs[15] = '{ALU_MULH, 8'hFF, 8'hFF, 8'hFE, 4'b0001, 9};
    vecs[16] = '{ALU_DIV,  8'h05, 8'h09, 8'h00, 4'b0010, 9};
    vecs[17] = '{ALU_REM,  8'h05, 8'h09, 8'h05, 4'b0000, 9};
    vecs[18] = '{ALU_SUB,  8'h80, 8'h01, 8'h7F, 4'b1100, 1};
    vecs[19] = '{ALU_OR,   8'h0F, 8'h30, 8'h3F, 4'b0000, 1};
    vecs[20] = '{ALU_AND,  8'hF0, 8'h9C, 8'h90, 4'b0001, 1};
    vecs[21] = '{ALU_SUB,  8'h07, 8'h07, 8'h00, 4'b1010, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    alu_op    = ALU_ADD;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flags", 32'(fl_bits()), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 22; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
      chk($sformatf("vec%0d_out", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: MUL result held while consumer stalls, queued ADD waits
    drain();
    @(negedge clk);
    out_ready = 1'b0;
    alu_op    = ALU_MUL;
    in1       = 8'h12;
    in2       = 8'h10;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd9);
    @(negedge clk);
    alu_op   = ALU_ADD;
    in1      = 8'h03;
    in2      = 8'h04;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_out", 32'(out), 32'h20);
      chk("bp_flags", 32'(fl_bits()), 32'b1100);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_queued_valid", 32'(out_valid), 32'd1);
    chk("bp_queued_out", 32'(out), 32'h07);
    chk("bp_queued_flags", 32'(fl_bits()), 32'b0000);

    // Reset mid-DIV discards the pending result
    drain();
    @(negedge clk);
    alu_op   = ALU_DIV;
    in1      = 8'hC8;
    in2      = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_flags", 32'(fl_bits()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    issue(ALU_ADD, 8'h01, 8'h02, r, f, lat);
    chk("post_rst_out", 32'(r), 32'h03);

    // Randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      opi = $urandom_range(0, 15);
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      model(opi, int'(ra), int'(rb), er, ef, elat);
      issue(alu_opcode_t'(4'(opi)), ra, rb, r, f, lat);
      chk($sformatf("rnd%0d_op%0d_out", i, opi), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_op%0d_flags", i, opi), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d_op%0d_lat", i, opi), 32'(lat), 32'(elat));
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
